// File: rtl/uart_cmd_parser.sv
// uart_cmd_parser
// Decodes single-byte commands from a UART receiver and issues a one-byte
// response ('K' on success, '?' on rejection or timeout) to the transmitter.
//
//   r/R -> cmd_run pulse     c/C -> cmd_clear pulse     m/M -> cmd_mode pulse
//   s/S <hex><hex>           -> set_value update with set_valid strobe
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   rx_data    received byte, valid while rx_done=1
//   rx_done    one-cycle receive strobe
//   tx_busy    transmitter busy
//   tx_data    response byte (held until the next response)
//   tx_start   one-cycle transmit request
//   cmd_run    one-cycle run pulse
//   cmd_clear  one-cycle clear pulse
//   cmd_mode   one-cycle mode-toggle pulse
//   set_value  last accepted set value
//   set_valid  one-cycle strobe when set_value updates
//   err        one-cycle strobe on rejected byte or timeout
//
// state  | meaning
// IDLE   | waiting for a command byte
// HEX_HI | set command seen, waiting for the high hex digit
// HEX_LO | high nibble stored, waiting for the low hex digit
module uart_cmd_parser #(
    parameter int TIMEOUT_CYC = 100_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       cmd_run,
    output logic       cmd_clear,
    output logic       cmd_mode,
    output logic [7:0] set_value,
    output logic       set_valid,
    output logic       err
);

    localparam int          CW      = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    // The counter "reaches" TIMEOUT_CYC-1 on the edge where it would step
    // from TIMEOUT_CYC-2, so the abort is registered on that same edge.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYC - 2);
    localparam logic [7:0]  CH_OK   = 8'h4B;
    localparam logic [7:0]  CH_BAD  = 8'h3F;

    typedef enum logic [1:0] {IDLE, HEX_HI, HEX_LO} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [3:0]    hi_nib, hi_nib_nxt;
    logic          resp_pending;
    logic [7:0]    resp_char;
    logic          q_en;
    logic [7:0]    q_char;
    logic          run_nxt, clear_nxt, mode_nxt, setv_nxt, err_nxt;
    logic [7:0]    set_value_nxt;
    logic          is_hex;
    logic [3:0]    nib;

    always_comb begin
        is_hex = 1'b1;
        nib    = 4'h0;
        if (rx_data >= 8'h30 && rx_data <= 8'h39)
            nib = rx_data[3:0];
        else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66))
            nib = rx_data[3:0] + 4'd9;
        else
            is_hex = 1'b0;
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        hi_nib_nxt    = hi_nib;
        set_value_nxt = set_value;
        q_en          = 1'b0;
        q_char        = CH_OK;
        run_nxt       = 1'b0;
        clear_nxt     = 1'b0;
        mode_nxt      = 1'b0;
        setv_nxt      = 1'b0;
        err_nxt       = 1'b0;
        case (state)
            IDLE: begin
                if (rx_done) begin
                    case (rx_data)
                        8'h72, 8'h52: begin run_nxt   = 1'b1; q_en = 1'b1; end
                        8'h63, 8'h43: begin clear_nxt = 1'b1; q_en = 1'b1; end
                        8'h6D, 8'h4D: begin mode_nxt  = 1'b1; q_en = 1'b1; end
                        8'h73, 8'h53: begin
                            state_nxt = HEX_HI;
                            cnt_nxt   = '0;
                        end
                        default: begin
                            err_nxt = 1'b1;
                            q_en    = 1'b1;
                            q_char  = CH_BAD;
                        end
                    endcase
                end
            end
            HEX_HI, HEX_LO: begin
                if (rx_done) begin
                    cnt_nxt = '0;
                    if (!is_hex) begin
                        err_nxt   = 1'b1;
                        q_en      = 1'b1;
                        q_char    = CH_BAD;
                        state_nxt = IDLE;
                    end else if (state == HEX_HI) begin
                        hi_nib_nxt = nib;
                        state_nxt  = HEX_LO;
                    end else begin
                        set_value_nxt = {hi_nib, nib};
                        setv_nxt      = 1'b1;
                        q_en          = 1'b1;
                        state_nxt     = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_nxt   = 1'b1;
                    q_en      = 1'b1;
                    q_char    = CH_BAD;
                    cnt_nxt   = '0;
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            hi_nib       <= 4'h0;
            resp_pending <= 1'b0;
            resp_char    <= 8'h00;
            tx_data      <= 8'h00;
            tx_start     <= 1'b0;
            cmd_run      <= 1'b0;
            cmd_clear    <= 1'b0;
            cmd_mode     <= 1'b0;
            set_value    <= 8'h00;
            set_valid    <= 1'b0;
            err          <= 1'b0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            hi_nib    <= hi_nib_nxt;
            set_value <= set_value_nxt;
            cmd_run   <= run_nxt;
            cmd_clear <= clear_nxt;
            cmd_mode  <= mode_nxt;
            set_valid <= setv_nxt;
            err       <= err_nxt;
            tx_start  <= 1'b0;
            if (resp_pending && !tx_busy) begin
                tx_data      <= resp_char;
                tx_start     <= 1'b1;
                resp_pending <= 1'b0;
            end
            // A newly queued response replaces whatever is waiting.
            if (q_en) begin
                resp_pending <= 1'b1;
                resp_char    <= q_char;
            end
        end
    end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Directed bench for uart_cmd_parser. Inputs change 1 time unit after the
// rising edge; outputs are sampled at that same point, so a value registered
// on the edge that samples rx_done is seen right after send_byte returns.
module tb_uart_cmd_parser;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_data;
    logic       rx_done;
    logic       tx_busy;
    logic [7:0] tx_data;
    logic       tx_start;
    logic       cmd_run;
    logic       cmd_clear;
    logic       cmd_mode;
    logic [7:0] set_value;
    logic       set_valid;
    logic       err;

    int n_tests = 0;
    int n_fail  = 0;
    int n_txs   = 0;
    int n_setv  = 0;
    int n_err   = 0;

    uart_cmd_parser #(.TIMEOUT_CYC(100)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_done   (rx_done),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .cmd_run   (cmd_run),
        .cmd_clear (cmd_clear),
        .cmd_mode  (cmd_mode),
        .set_value (set_value),
        .set_valid (set_valid),
        .err       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tx_start)  n_txs  <= n_txs + 1;
        if (set_valid) n_setv <= n_setv + 1;
        if (err)       n_err  <= n_err + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        tick();
        rx_data = b;
        rx_done = 1'b1;
        tick();
        rx_done = 1'b0;
    endtask

    function automatic logic [5:0] outs();
        return {tx_start, cmd_run, cmd_clear, cmd_mode, set_valid, err};
    endfunction

    initial begin
        int n;
        int base;
        rst     = 1'b1;
        rx_data = 8'h00;
        rx_done = 1'b0;
        tx_busy = 1'b0;
        tick();
        tick();
        check("reset_pulses", {26'd0, outs()}, 32'h0);
        check("reset_tx_data", tx_data, 8'h00);
        check("reset_set_value", set_value, 8'h00);
        rst = 1'b0;
        tick();

        // 'R': cmd_run one cycle after rx_done, tx_start with 'K' one later
        send_byte(8'h52);
        check("run_pulse", {26'd0, outs()}, 32'b010000);
        tick();
        check("run_tx_start", {26'd0, outs()}, 32'b100000);
        check("run_tx_data", tx_data, 8'h4B);
        tick();
        check("run_quiet", {26'd0, outs()}, 32'h0);

        // 'm' -> cmd_mode
        send_byte(8'h6D);
        check("mode_pulse", {26'd0, outs()}, 32'b000100);
        tick();
        tick();

        // 'S','3','a' -> set_value 0x3A
        base = n_err;
        send_byte(8'h53);
        send_byte(8'h33);
        check("set_mid_value", set_value, 8'h00);
        send_byte(8'h61);
        check("set_valid", {26'd0, outs()}, 32'b000010);
        check("set_value", set_value, 8'h3A);
        tick();
        check("set_tx_start", {31'd0, tx_start}, 32'd1);
        check("set_tx_data", tx_data, 8'h4B);
        tick();
        check("set_valid_count", n_setv, 1);
        check("set_no_err", n_err - base, 0);

        // 'x' rejected, then 'c' still works
        send_byte(8'h78);
        check("bad_err", {26'd0, outs()}, 32'b000001);
        tick();
        check("bad_tx_data", tx_data, 8'h3F);
        send_byte(8'h63);
        check("clear_pulse", {26'd0, outs()}, 32'b001000);
        tick();
        check("clear_tx_data", tx_data, 8'h4B);

        // timeout: 'S','F', idle. Latency counted like the cmd pulses
        // (registered on the rx_done edge = 1 cycle), so expect 100.
        send_byte(8'h53);
        send_byte(8'h46);
        n = 1;
        while (!err && n < 200) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 100);
        tick();
        check("timeout_tx_data", tx_data, 8'h3F);
        check("timeout_set_value", set_value, 8'h3A);

        // hex digit arriving on the would-be expiry cycle wins
        send_byte(8'h53);
        repeat (97) tick();
        base = n_err;
        send_byte(8'h37);
        repeat (5) tick();
        check("timeout_preempted", n_err - base, 0);
        send_byte(8'h42);
        check("late_set_value", set_value, 8'h7B);
        tick();
        tick();

        // tx_busy held: 'r' then 'q' -> single '?' once busy drops
        tx_busy = 1'b1;
        base = n_txs;
        send_byte(8'h72);
        send_byte(8'h71);
        repeat (4) tick();
        check("busy_no_tx", n_txs - base, 0);
        tx_busy = 1'b0;
        tick();
        check("busy_tx_start", {31'd0, tx_start}, 32'd1);
        check("busy_tx_data", tx_data, 8'h3F);
        repeat (4) tick();
        check("busy_single_tx", n_txs - base, 1);

        // reset between 'S' and the first digit
        send_byte(8'h53);
        rst = 1'b1;
        tick();
        check("midrst_pulses", {26'd0, outs()}, 32'h0);
        check("midrst_set_value", set_value, 8'h00);
        check("midrst_tx_data", tx_data, 8'h00);
        rst = 1'b0;
        base = n_txs + n_err + n_setv;
        repeat (4) tick();
        check("midrst_quiet", n_txs + n_err + n_setv - base, 0);
        send_byte(8'h35);
        check("midrst_err", {26'd0, outs()}, 32'b000001);
        tick();
        check("midrst_tx_data_bad", tx_data, 8'h3F);
        check("midrst_set_kept", set_value, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_parser.md
UART_CMD_PARSER -- requirements
Module: uart_cmd_parser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 100_000_000, meaning the number of idle clocks allowed between hex digits of a set command before it is aborted.
REQ-002 SHALL have port clk  input  1  system clock (100 MHz); all logic is on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rx_data  input  8  received byte from the UART receiver; valid only while rx_done=1.
REQ-005 SHALL have port rx_done  input  1  one-cycle strobe marking a received byte.
REQ-006 SHALL have port tx_busy  input  1  UART transmitter busy flag.
REQ-007 SHALL have port tx_data  output  8  response byte sent to the UART transmitter.
REQ-008 SHALL have port tx_start  output  1  one-cycle transmit request.
REQ-009 SHALL have port cmd_run  output  1  one-cycle run pulse.
REQ-010 SHALL have port cmd_clear  output  1  one-cycle clear pulse.
REQ-011 SHALL have port cmd_mode  output  1  one-cycle mode-toggle pulse.
REQ-012 SHALL have port set_value  output  8  last accepted set value; held between commands.
REQ-013 SHALL have port set_valid  output  1  one-cycle strobe asserted when set_value updates.
REQ-014 SHALL have port err  output  1  one-cycle strobe on a rejected byte or a timeout.

Function
REQ-015 SHALL implement FSM states IDLE, HEX_HI and HEX_LO; bytes are acted on only in cycles where rx_done=1.
REQ-016 In IDLE, SHALL decode 'r'/'R' (0x72/0x52) -> cmd_run, 'c'/'C' -> cmd_clear, 'm'/'M' -> cmd_mode; each SHALL pulse for exactly 1 cycle, registered 1 cycle after rx_done, and queue response 'K' (0x4B).
REQ-017 In IDLE, SHALL treat 's'/'S' as a set command: go to HEX_HI, clear the timeout counter, and queue no response.
REQ-018 In IDLE, any other byte SHALL pulse err and queue response '?' (0x3F); the state remains IDLE.
REQ-019 Hex digits SHALL be 0x30-0x39, 0x41-0x46 and 0x61-0x66 (case-insensitive), decoding to a 4-bit nibble.
REQ-020 In HEX_HI, a hex digit SHALL store the high nibble and move to HEX_LO with the timeout counter cleared; a non-hex byte SHALL pulse err, queue '?', and return to IDLE.
REQ-021 In HEX_LO, a hex digit SHALL load set_value={hi,lo}, pulse set_valid 1 cycle after rx_done, queue 'K', and return to IDLE; a non-hex byte SHALL behave as in REQ-020, leaving set_value unchanged.
REQ-022 In HEX_HI and HEX_LO, the timeout counter SHALL increment every cycle without rx_done; on reaching TIMEOUT_CYC-1 the FSM SHALL pulse err, queue '?', and return to IDLE.
REQ-023 If rx_done coincides with timeout expiry, the byte SHALL take priority and the timeout SHALL NOT fire.
REQ-024 The response queue SHALL be one entry (resp_pending flag plus resp_char); a queued response SHALL overwrite any pending one (latest wins).
REQ-025 When resp_pending=1 and tx_busy=0, SHALL drive tx_data=resp_char, pulse tx_start for 1 cycle, and clear resp_pending in the same cycle.
REQ-026 tx_data SHALL hold its value after tx_start until the next response is issued.
REQ-027 Minimum latency from rx_done to tx_start SHALL be 2 cycles when tx_busy=0.
REQ-028 At most one of cmd_run, cmd_clear, cmd_mode, set_valid or err SHALL be asserted in any cycle.

Reset
REQ-029 While rst=1, SHALL force: state IDLE, timeout counter 0, resp_pending 0, hi nibble 0, tx_data 0x00, set_value 0x00, and tx_start, cmd_run, cmd_clear, cmd_mode, set_valid and err all 0.
REQ-030 Reset asserted mid-command (HEX_HI/HEX_LO) SHALL discard the partial command and any pending response; no pulse SHALL be emitted on release.

Verification
REQ-031 Bench SHALL cover: rx 'R', tx_busy=0 -> cmd_run pulses 1 cycle after rx_done; tx_start with tx_data=0x4B 2 cycles after rx_done.
REQ-032 Bench SHALL cover: rx 'S','3','a' -> set_value=0x3A, set_valid pulses once, response 0x4B; no err.
REQ-033 Bench SHALL cover: rx 'x' (0x78) -> err pulse, tx_data=0x3F; the next 'c' still yields cmd_clear.
REQ-034 Bench SHALL cover: TIMEOUT_CYC=100, rx 'S','F', then no byte -> err pulses 100 cycles after the 'F' strobe, response 0x3F, set_value unchanged.
REQ-035 Bench SHALL cover: tx_busy held 1 while 'r' then 'q' arrive -> a single tx_start after tx_busy falls, carrying 0x3F.
REQ-036 Bench SHALL cover: rst asserted between 'S' and the first hex digit -> all outputs 0; a subsequent '5' yields err and 0x3F.
